union_tagged_fifo: RTL and testbench
====================================

// Module: union_tagged_fifo
// PURPOSE
//  Parametrised FIFO whose entries are a tagged unpacked union: a TAG_W-bit kind tag plus a
//  DATA_W-bit payload. The payload is viewable as signed int, raw logic vector or shortreal bits.
//  Sits between a producer and a consumer of mixed-kind numeric messages, with valid/ready on both sides.
//  Generalises the fixed two-member union to configurable width, depth and kind count.
//  Adds buffering, illegal-tag checking and per-kind statistics.
// PARAMETERS
//  DATA_W     32  payload width in bits; legal range 1..64.
//  DEPTH      4   entry count; power of two, >= 2.
//  NUM_KINDS  3   legal tag values are 0..NUM_KINDS-1 (0=int, 1=raw, 2=shortreal bits).
//  TAG_W      2   tag width; requires 2**TAG_W >= NUM_KINDS.
// PORTS
//  clk         in   1                  clock, rising edge.
//  rst_n       in   1                  asynchronous reset, active-low.
//  in_valid    in   1                  producer presents an entry.
//  in_ready    out  1                  FIFO can accept an entry (not full).
//  in_tag      in   TAG_W              kind of the incoming payload.
//  in_data     in   DATA_W             incoming payload bits.
//  out_valid   out  1                  head entry available (not empty).
//  out_ready   in   1                  consumer accepts the head entry.
//  out_tag     out  TAG_W              head entry tag.
//  out_data    out  DATA_W             head entry raw view.
//  out_int     out  32                 head payload as int: sign-extended, or truncated to 32 bits.
//  count       out  $clog2(DEPTH)+1    number of stored entries.
//  tag_err     out  1                  sticky flag: an illegal tag was offered.
//  kind_cnt    out  NUM_KINDS*16       per-kind accepted-push counters; kind k occupies bits [16k+:16].
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous):
//    - wr_ptr, rd_ptr and count go to 0; out_valid=0; in_ready=1.
//    - tag_err=0; kind_cnt all 0.
//    - Storage contents are don't-care.
//  - Push occurs when in_valid && in_ready && in_tag < NUM_KINDS.
//    - Writes {tag,data} at wr_ptr; wr_ptr increments modulo DEPTH.
//  - Illegal-tag entry (in_valid && in_ready && in_tag >= NUM_KINDS):
//    - Handshake completes (it is consumed); the entry is dropped.
//    - tag_err is set on the next edge; no counter changes.
//  - Pop occurs when out_valid && out_ready; rd_ptr increments modulo DEPTH.
//  - Handshake signals:
//    - in_ready = (count != DEPTH), combinational from registered state only.
//    - out_valid = (count != 0).
//    - in_ready must not depend on out_ready: no pass-through when full.
//  - out_tag, out_data and out_int are driven combinationally from the entry at rd_ptr.
//    - They are stable while out_valid && !out_ready.
//    - They are don't-care when out_valid=0.
//  - Latency: an entry pushed at edge N is visible on out_* after edge N (1 cycle). There is no bypass when empty.
//  - Simultaneous push and pop: count is unchanged and both pointers advance.
//    - Legal when full? No: in_ready=0 when full, so only the pop happens.
//    - When empty, only the push happens (out_valid was 0).
//  - Pointer wrap: pointers are $clog2(DEPTH) bits wide and wrap naturally.
//    - Full/empty is decided from count, never from pointer equality.
//  - out_int rule: if DATA_W<32, sign-extend from bit DATA_W-1; else take out_data[31:0].
//  - kind_cnt[k] increments on each legal push of kind k and saturates at 16'hFFFF.
//  - tag_err clears only on reset.
//  - A reset asserted mid-transfer discards all entries. Outputs return to reset values immediately (asynchronously).
// TESTING
//  1. Reset, then push tag0 0xFFFF_FFFE
//     -> next cycle out_valid=1, out_int=-2, count=1, kind_cnt[0]=1.
//  2. Push 4 entries with out_ready=0 (DEPTH=4)
//     -> in_ready=0, count=4. A 5th in_valid is held and not stored.
//  3. When full, assert in_valid and out_ready together
//     -> only the pop happens; count goes 4->3; the next cycle accepts the push.
//  4. Continuous push+pop for 10 cycles, tags 0,1,2 cycling
//     -> in-order output, pointers wrap, count stays constant.
//     -> kind_cnt reads 4/3/3 (or matches the stimulus).
//  5. Push in_tag=3
//     -> in_ready stays 1, entry dropped, tag_err=1, count unchanged, kind_cnt unchanged.
//  6. Assert rst_n low mid-stream with count=3
//     -> count=0, out_valid=0, tag_err=0 asynchronously.
//  7. DATA_W=16 build: push 0x8001
//     -> out_int=0xFFFF_8001.

Source files
------------

// File: rtl/union_tagged_fifo.sv
// FIFO of tagged entries {kind tag, payload}. Valid/ready on both sides; entries with illegal
// tags are consumed and dropped, and accepted pushes are counted per kind.
module union_tagged_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int NUM_KINDS = 3,
    parameter int TAG_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [TAG_W-1:0]            in_tag,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TAG_W-1:0]            out_tag,
    output logic [DATA_W-1:0]           out_data,
    output logic [31:0]                 out_int,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        tag_err,
    output logic [NUM_KINDS*16-1:0]     kind_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [TAG_W:0]   KIND_LIM  = (TAG_W+1)'(NUM_KINDS);

    // Payload views share the same bits; the shortreal view is simply the raw bits at 32 wide.
    typedef union packed {
        logic        [DATA_W-1:0] raw;
        logic signed [DATA_W-1:0] sval;
    } payload_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        payload_t         data;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_tag_err;
    logic [15:0]        r_kind_cnt [NUM_KINDS];

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_tag_ok;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    entry_t             w_head;

    assign w_in_ready  = (r_count != FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_tag_ok    = ({1'b0, in_tag} < KIND_LIM);
    assign w_accept    = in_valid && w_in_ready;
    assign w_push      = w_accept && w_tag_ok;
    assign w_pop       = w_out_valid && out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    // Storage needs no reset: out_* are don't-care whenever count is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr].tag      <= in_tag;
            r_mem[r_wr_ptr].data.raw <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_tag_err <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_accept && !w_tag_ok)
                r_tag_err <= 1'b1;
        end
    end

    // Per-kind push counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_KINDS; k++)
                r_kind_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_KINDS; k++) begin
                if (w_push && ({1'b0, in_tag} == (TAG_W+1)'(k)) && (r_kind_cnt[k] != 16'hFFFF))
                    r_kind_cnt[k] <= r_kind_cnt[k] + 16'd1;
            end
        end
    end

    always_comb begin
        kind_cnt = '0;
        for (int k = 0; k < NUM_KINDS; k++)
            kind_cnt[16*k +: 16] = r_kind_cnt[k];
    end

    generate
        if (DATA_W < 32) begin : g_int_ext
            assign out_int = {{(32-DATA_W){w_head.data.sval[DATA_W-1]}}, w_head.data.raw};
        end else begin : g_int_trunc
            assign out_int = w_head.data.raw[31:0];
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_tag   = w_head.tag;
    assign out_data  = w_head.data.raw;
    assign count     = r_count;
    assign tag_err   = r_tag_err;

endmodule

// File: tb/tb_union_tagged_fifo.sv
// Directed bench for union_tagged_fifo: queue-based reference model checked every cycle,
// plus literal expectations, and a 16-bit payload instance for the sign-extension rule.
module tb_union_tagged_fifo;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 4;
    localparam int NUM_KINDS = 3;
    localparam int TAG_W     = 2;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    logic                       clk;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic [TAG_W-1:0]           in_tag;
    logic [DATA_W-1:0]          in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [TAG_W-1:0]           out_tag;
    logic [DATA_W-1:0]          out_data;
    logic [31:0]                out_int;
    logic [CNT_W-1:0]           count;
    logic                       tag_err;
    logic [NUM_KINDS*16-1:0]    kind_cnt;

    logic                       s_in_valid;
    logic                       s_in_ready;
    logic [TAG_W-1:0]           s_in_tag;
    logic [15:0]                s_in_data;
    logic                       s_out_valid;
    logic                       s_out_ready;
    logic [TAG_W-1:0]           s_out_tag;
    logic [15:0]                s_out_data;
    logic [31:0]                s_out_int;
    logic [CNT_W-1:0]           s_count;
    logic                       s_tag_err;
    logic [NUM_KINDS*16-1:0]    s_kind_cnt;

    union_tagged_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_KINDS(NUM_KINDS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
        .out_int(out_int), .count(count), .tag_err(tag_err), .kind_cnt(kind_cnt)
    );

    union_tagged_fifo #(.DATA_W(16), .DEPTH(DEPTH), .NUM_KINDS(NUM_KINDS), .TAG_W(TAG_W)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_tag(s_in_tag), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_tag(s_out_tag), .out_data(s_out_data),
        .out_int(s_out_int), .count(s_count), .tag_err(s_tag_err), .kind_cnt(s_kind_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {tag,data}, per-kind counts, sticky error.
    logic [TAG_W+DATA_W-1:0] m_q[$];
    int unsigned             m_kc [NUM_KINDS] = '{default: 0};
    bit                      m_err = 1'b0;
    bit                      m_rdy;
    bit                      m_pop;
    bit                      cmp_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            for (int k = 0; k < NUM_KINDS; k++) m_kc[k] = 0;
            m_err = 1'b0;
        end else begin
            m_rdy = (m_q.size() != DEPTH);
            m_pop = (m_q.size() != 0) && out_ready;
            if (m_pop) void'(m_q.pop_front());
            if (in_valid && m_rdy) begin
                if (int'(in_tag) < NUM_KINDS) begin
                    m_q.push_back({in_tag, in_data});
                    if (m_kc[in_tag] != 65535) m_kc[in_tag]++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [NUM_KINDS*16-1:0] e_kc;
        logic [TAG_W+DATA_W-1:0] head;
        logic [31:0]             e_int;
        if (cmp_en) begin
            e_kc = '0;
            for (int k = 0; k < NUM_KINDS; k++) e_kc[16*k +: 16] = 16'(m_kc[k]);
            chk("m_in_ready",  64'(in_ready),  64'(m_q.size() != DEPTH));
            chk("m_out_valid", 64'(out_valid), 64'(m_q.size() != 0));
            chk("m_count",     64'(count),     64'(m_q.size()));
            chk("m_tag_err",   64'(tag_err),   64'(m_err));
            chk("m_kind_cnt",  64'(kind_cnt),  64'(e_kc));
            if (m_q.size() != 0) begin
                head  = m_q[0];
                e_int = 32'($signed(head[DATA_W-1:0]));
                chk("m_out_tag",  64'(out_tag),  64'(head[TAG_W+DATA_W-1:DATA_W]));
                chk("m_out_data", 64'(out_data), 64'(head[DATA_W-1:0]));
                chk("m_out_int",  64'(out_int),  64'(e_int));
            end
        end
    end

    task automatic cyc(input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                       input logic ordy);
        in_valid  = v;
        in_tag    = t;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_tag      = '0;
        in_data     = '0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_tag    = '0;
        s_in_data   = '0;
        s_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",    64'(count),     64'd0);
        chk("rst_in_ready", 64'(in_ready),  64'd1);
        chk("rst_out_vld",  64'(out_valid), 64'd0);
        chk("rst_tag_err",  64'(tag_err),   64'd0);
        chk("rst_kind_cnt", 64'(kind_cnt),  64'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Single push, visible one edge later.
        cyc(1'b1, 2'd0, 32'hFFFF_FFFE, 1'b0); idle();
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_int",   64'(out_int),   64'h0000_0000_FFFF_FFFE);
        chk("t1_count",     64'(count),     64'd1);
        chk("t1_kind0",     64'(kind_cnt[15:0]), 64'd1);
        cyc(1'b0, 2'd0, '0, 1'b1); idle();

        // Fill, then hold a fifth offer.
        cyc(1'b1, 2'd1, 32'd10, 1'b0);
        cyc(1'b1, 2'd2, 32'd11, 1'b0);
        cyc(1'b1, 2'd0, 32'd12, 1'b0);
        cyc(1'b1, 2'd1, 32'd13, 1'b0);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        chk("t2_count",    64'(count),    64'd4);
        cyc(1'b1, 2'd2, 32'h55, 1'b0);
        chk("t2_held_cnt", 64'(count),    64'd4);
        chk("t2_head",     64'(out_data), 64'd10);
        chk("t2_kinds",    64'(kind_cnt), 64'h0001_0002_0002);

        // Full with push and pop offered: pop only, then push lands.
        cyc(1'b1, 2'd2, 32'h55, 1'b1);
        chk("t3_count",    64'(count),    64'd3);
        chk("t3_head",     64'(out_data), 64'd11);
        cyc(1'b1, 2'd2, 32'h55, 1'b0);
        chk("t3_refill",   64'(count),    64'd4);
        chk("t3_kind2",    64'(kind_cnt[47:32]), 64'd2);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'd0, '0, 1'b1);
        idle();
        chk("t3_drained",  64'(count), 64'd0);

        // Streaming push+pop with cycling tags.
        for (int i = 0; i < 10; i++)
            cyc(1'b1, TAG_W'(i % 3), 32'h100 + 32'(i), 1'b1);
        idle();
        chk("t4_count", 64'(count),    64'd1);
        chk("t4_last",  64'(out_data), 64'h109);
        chk("t4_kinds", 64'(kind_cnt), 64'h0005_0005_0006);
        cyc(1'b0, 2'd0, '0, 1'b1); idle();

        // Illegal tag, empty and non-empty.
        chk("t5_ready_pre", 64'(in_ready), 64'd1);
        cyc(1'b1, 2'd3, 32'hDEAD, 1'b0); idle();
        chk("t5_tag_err", 64'(tag_err),  64'd1);
        chk("t5_count",   64'(count),    64'd0);
        chk("t5_kinds",   64'(kind_cnt), 64'h0005_0005_0006);
        cyc(1'b1, 2'd0, 32'h77, 1'b0);
        cyc(1'b1, 2'd3, 32'hBEEF, 1'b0);
        chk("t5_cnt_ne",  64'(count),    64'd1);
        chk("t5_head",    64'(out_data), 64'h77);
        cyc(1'b1, 2'd1, 32'h78, 1'b0);
        cyc(1'b1, 2'd2, 32'h79, 1'b0); idle();
        chk("t6_pre_cnt", 64'(count), 64'd3);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        chk("t6_count",    64'(count),     64'd0);
        chk("t6_out_vld",  64'(out_valid), 64'd0);
        chk("t6_tag_err",  64'(tag_err),   64'd0);
        chk("t6_in_ready", 64'(in_ready),  64'd1);
        chk("t6_kinds",    64'(kind_cnt),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 2'd1, 32'h42, 1'b0); idle();
        chk("t6_recover_tag", 64'(out_tag),  64'd1);
        chk("t6_recover_kc",  64'(kind_cnt), 64'h0000_0001_0000);

        // 16-bit payload sign extension.
        s_in_valid = 1'b1; s_in_tag = 2'd0; s_in_data = 16'h8001;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        chk("t7_valid", 64'(s_out_valid), 64'd1);
        chk("t7_int",   64'(s_out_int),   64'h0000_0000_FFFF_8001);
        s_in_valid = 1'b1; s_in_data = 16'h7FFF; s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        chk("t7_pos_int", 64'(s_out_int), 64'h0000_0000_0000_7FFF);
        chk("t7_count",   64'(s_count),   64'd1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
